// File: rtl/hc595_frame_sched.sv
// Frame scheduler for two cascaded SN74HC595 shift registers.
// Ports: clk/rst, req/data/ack per client, busy, frame_done, 595 data/shift/latch.
module hc595_frame_sched #(
  parameter int unsigned DIV     = 4,
  parameter logic [23:0] REFRESH = 24'd1_200_000,
  parameter logic [7:0]  INIT0   = 8'h00,
  parameter logic [7:0]  INIT1   = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       ack0,
  output logic       ack1,
  output logic       busy,
  output logic       frame_done,
  output logic       SN74HC595_data,
  output logic       SN74HC595_data_clk,
  output logic       SN74HC595_refresh_clk
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    shadow0_q, shadow0_d;
  logic [7:0]    shadow1_q, shadow1_d;
  logic [3:0]    bit_q, bit_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [23:0]   refcnt_q, refcnt_d;
  logic          pwrup_q, pwrup_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          sdata_q, sdata_d;
  logic          dclk_q, dclk_d;
  logic          rclk_q, rclk_d;

  logic [15:0]   frame_w;
  logic          phase_last;
  logic          refresh_hit;
  logic          start;

  assign frame_w     = {shadow1_q, shadow0_q};
  assign phase_last  = (phase_q == PH_LAST);
  assign refresh_hit = (REFRESH != 24'd0) &&
                       (refcnt_q == REFRESH - 24'd1);

  always_comb begin
    state_d   = state_q;
    shadow0_d = shadow0_q;
    shadow1_d = shadow1_q;
    bit_d     = bit_q;
    phase_d   = phase_q;
    refcnt_d  = refcnt_q;
    pwrup_d   = pwrup_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sdata_d   = sdata_q;
    dclk_d    = dclk_q;
    rclk_d    = rclk_q;
    start     = 1'b0;

    unique case (state_q)
      IDLE: begin
        start = req0 | req1 | pwrup_q | refresh_hit;
        if (req0) begin
          shadow0_d = data0;
          ack0_d    = 1'b1;
        end
        if (req1) begin
          shadow1_d = data1;
          ack1_d    = 1'b1;
        end
        if (start) begin
          state_d  = SHIFT_LO;
          bit_d    = 4'd15;
          phase_d  = '0;
          refcnt_d = '0;
          pwrup_d  = 1'b0;
          busy_d   = 1'b1;
          dclk_d   = 1'b0;
          // bit 15 is the MSB of the byte captured on this edge
          sdata_d  = shadow1_d[7];
        end else if (refcnt_q != 24'hFF_FFFF) begin
          refcnt_d = refcnt_q + 24'd1;
        end
      end
      SHIFT_LO: begin
        if (phase_last) begin
          state_d = SHIFT_HI;
          phase_d = '0;
          dclk_d  = 1'b1;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      SHIFT_HI: begin
        if (phase_last) begin
          phase_d = '0;
          dclk_d  = 1'b0;
          if (bit_q == 4'd0) begin
            state_d = LATCH;
            rclk_d  = 1'b1;
          end else begin
            state_d = SHIFT_LO;
            bit_d   = bit_q - 4'd1;
            sdata_d = frame_w[bit_q - 4'd1];
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      LATCH: begin
        if (phase_last) begin
          state_d = IDLE;
          phase_d = '0;
          rclk_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shadow0_q <= INIT0;
      shadow1_q <= INIT1;
      bit_q     <= '0;
      phase_q   <= '0;
      refcnt_q  <= '0;
      pwrup_q   <= 1'b1;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sdata_q   <= 1'b0;
      dclk_q    <= 1'b0;
      rclk_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow0_q <= shadow0_d;
      shadow1_q <= shadow1_d;
      bit_q     <= bit_d;
      phase_q   <= phase_d;
      refcnt_q  <= refcnt_d;
      pwrup_q   <= pwrup_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sdata_q   <= sdata_d;
      dclk_q    <= dclk_d;
      rclk_q    <= rclk_d;
    end
  end

  assign ack0                  = ack0_q;
  assign ack1                  = ack1_q;
  assign busy                  = busy_q;
  assign frame_done            = done_q;
  assign SN74HC595_data        = sdata_q;
  assign SN74HC595_data_clk    = dclk_q;
  assign SN74HC595_refresh_clk = rclk_q;

endmodule
